// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display reads win every cycle, while the hardware fill and
// the queued pixel writes share the slots the display leaves idle.
module vga_fb_arbiter #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    output logic [11:0]       pix_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_x,
    input  logic [6:0]        wr_y,
    input  logic [11:0]       wr_data,
    output logic              wr_drop,
    input  logic              clr_start,
    input  logic [11:0]       clr_color,
    output logic              clr_busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [11:0]       ram_wdata,
    input  logic [11:0]       ram_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(FB_W * FB_H - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [11:0]         clr_col;
    logic                rd_d;

    logic [ADDR_W+11:0]  fifo_mem [FIFO_DEPTH];
    logic [ADDR_W+11:0]  fifo_head;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W:0]      fifo_cnt;

    logic                disp_req;
    logic [ADDR_W-1:0]   disp_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic                wr_in_range;
    logic                wr_accept;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                clr_write;

    assign disp_req  = (pix_x != 10'h3FF) && (pix_y != 10'h3FF);
    assign disp_addr = ADDR_W'(pix_y >> SCALE_SHIFT) * ADDR_W'(FB_W)
                     + ADDR_W'(pix_x >> SCALE_SHIFT);

    assign wr_in_range = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
    assign wr_addr     = ADDR_W'(wr_y) * ADDR_W'(FB_W) + ADDR_W'(wr_x);

    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_head  = fifo_mem[rd_ptr];

    // Gating with rst keeps every output at 0 for the whole reset, not just after an edge.
    assign wr_ready  = !rst && !fifo_full;
    assign wr_accept = wr_valid && wr_ready;
    assign push      = wr_accept && wr_in_range;
    assign clr_write = (state == CLEAR) && !disp_req;
    assign pop       = !rst && (state == IDLE) && !disp_req && !fifo_empty;

    assign clr_busy = (state == CLEAR);
    assign pix_data = rd_d ? ram_rdata : 12'h000;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) begin
            if (disp_req) begin
                ram_en   = 1'b1;
                ram_addr = disp_addr;
            end else if (state == CLEAR) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_cnt;
                ram_wdata = clr_col;
            end else if (!fifo_empty) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = fifo_head[ADDR_W+11:12];
                ram_wdata = fifo_head[11:0];
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    // A clr_start seen while already clearing is ignored so the fill never restarts midway.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
            clr_col <= '0;
        end else if (state == IDLE) begin
            if (clr_start) begin
                state   <= CLEAR;
                clr_cnt <= '0;
                clr_col <= clr_color;
            end
        end else if (clr_write) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_CELL) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            rd_d    <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            rd_d    <= disp_req;
            wr_drop <= wr_accept && !wr_in_range;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a scoreboard of expected RAM writes and
// expected pix_data values, plus a small model of the fill FSM.
module tb_vga_fb_arbiter;

    localparam int FIFO_DEPTH = 4;
    localparam int CELLS      = 160 * 120;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [11:0] wr_data;
    logic        wr_drop;
    logic        clr_start;
    logic [11:0] clr_color;
    logic        clr_busy;
    logic        ram_en;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [26:0] exp_wr[$];
    logic [11:0] exp_pix[$];
    bit          m_clear;
    int          m_cnt;
    logic [11:0] m_color;
    bit          m_drop;
    bit          prev_req;
    int          prev_addr;

    vga_fb_arbiter dut (
        .vga_clk   (vga_clk),
        .rst       (rst),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_data  (pix_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .wr_drop   (wr_drop),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic int dispAddr(input logic [9:0] px, input logic [9:0] py);
        return (((int'(py) >> 2) * 160) + (int'(px) >> 2)) & 32'h7FFF;
    endfunction

    // The bench plays the RAM: data returned depends on the address the model predicts.
    function automatic logic [11:0] rdataOf(input int a);
        logic [11:0] v;
        if (a == 4075) begin
            return 12'hABC;
        end
        v = 12'(a) ^ 12'h5A5;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit          disp;
        int          a;
        bit          exp_ready;
        bit          start_ok;
        logic [11:0] exp_pd;
        logic [26:0] head;
        disp      = (pix_x != 10'h3FF) && (pix_y != 10'h3FF);
        a         = dispAddr(pix_x, pix_y);
        exp_ready = exp_wr.size() < FIFO_DEPTH;
        start_ok  = clr_start && !m_clear;
        exp_pd    = (exp_pix.size() > 0) ? exp_pix.pop_front() : 12'h000;

        check("pix_data", 32'(pix_data), 32'(exp_pd));
        check("wr_ready", 32'(wr_ready), 32'(exp_ready));
        check("wr_drop", 32'(wr_drop), 32'(m_drop));
        check("clr_busy", 32'(clr_busy), 32'(m_clear));

        if (disp) begin
            check("rd_en", 32'(ram_en), 32'd1);
            check("rd_we", 32'(ram_we), 32'd0);
            check("rd_addr", 32'(ram_addr), 32'(a));
        end else if (m_clear) begin
            check("clr_en", 32'(ram_en), 32'd1);
            check("clr_we", 32'(ram_we), 32'd1);
            check("clr_addr", 32'(ram_addr), 32'(m_cnt));
            check("clr_wdata", 32'(ram_wdata), 32'(m_color));
            m_cnt++;
            if (m_cnt == CELLS) begin
                m_clear = 1'b0;
            end
        end else if (exp_wr.size() > 0) begin
            head = exp_wr.pop_front();
            check("fifo_en", 32'(ram_en), 32'd1);
            check("fifo_we", 32'(ram_we), 32'd1);
            check("fifo_addr", 32'(ram_addr), 32'(head[26:12]));
            check("fifo_wdata", 32'(ram_wdata), 32'(head[11:0]));
        end else begin
            check("idle_en", 32'(ram_en), 32'd0);
        end

        if (start_ok) begin
            m_clear = 1'b1;
            m_cnt   = 0;
            m_color = clr_color;
        end

        m_drop = 1'b0;
        if (wr_valid && exp_ready) begin
            if (wr_x < 8'd160 && wr_y < 7'd120) begin
                exp_wr.push_back({15'(int'(wr_y) * 160 + int'(wr_x)), wr_data});
            end else begin
                m_drop = 1'b1;
            end
        end

        exp_pix.push_back(disp ? rdataOf(a) : 12'h000);
        prev_req  = disp;
        prev_addr = a;
    endtask

    task automatic applyStimulus(input logic [9:0] px, input logic [9:0] py,
                                 input logic wv, input logic [7:0] wx, input logic [6:0] wy,
                                 input logic [11:0] wd, input logic cs);
        pix_x     = px;
        pix_y     = py;
        wr_valid  = wv;
        wr_x      = wx;
        wr_y      = wy;
        wr_data   = wd;
        clr_start = cs;
        ram_rdata = prev_req ? rdataOf(prev_addr) : 12'hEEE;
        #1;
        checkOutput();
        @(negedge vga_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(10'h3FF, 10'h3FF, 1'b0, 8'd0, 7'd0, 12'h000, 1'b0);
        end
    endtask

    // Reset is raised between edges and checked before any clock edge can intervene.
    task automatic resetDut();
        pix_x     = 10'd40;
        pix_y     = 10'd40;
        wr_valid  = 1'b0;
        clr_start = 1'b0;
        ram_rdata = 12'hEEE;
        rst       = 1'b1;
        #1;
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_wr_drop", 32'(wr_drop), 32'd0);
        check("rst_clr_busy", 32'(clr_busy), 32'd0);
        @(negedge vga_clk);
        @(negedge vga_clk);
        pix_x = 10'h3FF;
        pix_y = 10'h3FF;
        rst   = 1'b0;
        exp_wr.delete();
        exp_pix.delete();
        m_clear   = 1'b0;
        m_cnt     = 0;
        m_drop    = 1'b0;
        prev_req  = 1'b0;
        prev_addr = 0;
    endtask

    initial begin
        int guard;
        wr_x      = 8'd0;
        wr_y      = 7'd0;
        wr_data   = 12'h000;
        clr_color = 12'h000;
        m_color   = 12'h000;
        resetDut();
        idle(2);

        $display("[TB] display reads");
        applyStimulus(10'd300, 10'd100, 1'b0, 8'd0, 7'd0, 12'h000, 1'b0);
        applyStimulus(10'h3FF, 10'd100, 1'b0, 8'd0, 7'd0, 12'h000, 1'b0);
        applyStimulus(10'd0, 10'd0, 1'b0, 8'd0, 7'd0, 12'h000, 1'b0);
        applyStimulus(10'd639, 10'd479, 1'b0, 8'd0, 7'd0, 12'h000, 1'b0);
        applyStimulus(10'd7, 10'd10, 1'b0, 8'd0, 7'd0, 12'h000, 1'b0);
        applyStimulus(10'd100, 10'h3FF, 1'b0, 8'd0, 7'd0, 12'h000, 1'b0);
        idle(1);

        $display("[TB] single write in blanking");
        applyStimulus(10'h3FF, 10'h3FF, 1'b1, 8'd10, 7'd5, 12'hF00, 1'b0);
        idle(2);

        $display("[TB] queue fills while display holds the RAM");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(10'(100 + i * 4), 10'd50, 1'b1, 8'(i), 7'd7, 12'(12'h100 + i), 1'b0);
        end
        idle(6);

        $display("[TB] out-of-range and boundary writes");
        applyStimulus(10'h3FF, 10'h3FF, 1'b1, 8'd160, 7'd0, 12'h0AA, 1'b0);
        applyStimulus(10'h3FF, 10'h3FF, 1'b1, 8'd0, 7'd120, 12'h0BB, 1'b0);
        applyStimulus(10'h3FF, 10'h3FF, 1'b1, 8'd159, 7'd119, 12'h0CC, 1'b0);
        applyStimulus(10'h3FF, 10'h3FF, 1'b1, 8'd1, 7'd1, 12'h0DD, 1'b0);
        idle(3);

        $display("[TB] full fill with no display");
        clr_color = 12'h00F;
        applyStimulus(10'h3FF, 10'h3FF, 1'b0, 8'd0, 7'd0, 12'h000, 1'b1);
        clr_color = 12'h777;
        for (int i = 0; i < CELLS + 10; i++) begin
            applyStimulus(10'h3FF, 10'h3FF, i == 5, 8'd3, 7'd4, 12'h123, i == 10);
        end

        $display("[TB] fill interleaved with display bursts");
        clr_color = 12'h0F0;
        applyStimulus(10'h3FF, 10'h3FF, 1'b0, 8'd0, 7'd0, 12'h000, 1'b1);
        for (int i = 0; i < 30800; i++) begin
            if ((i % 8) < 3) begin
                applyStimulus(10'((i * 7) % 640), 10'((i / 8) % 480), i == 100, 8'd20, 7'd30,
                              12'h456, 1'b0);
            end else begin
                applyStimulus(10'h3FF, 10'h3FF, 1'b0, 8'd0, 7'd0, 12'h000, 1'b0);
            end
        end

        $display("[TB] reset in the middle of a fill");
        clr_color = 12'h321;
        applyStimulus(10'h3FF, 10'h3FF, 1'b0, 8'd0, 7'd0, 12'h000, 1'b1);
        guard = 0;
        while (m_cnt < 1000 && guard < 1100) begin
            applyStimulus(10'h3FF, 10'h3FF, guard == 500, 8'd9, 7'd9, 12'h999, 1'b0);
            guard++;
        end
        check("fill_reached_1000", 32'(guard), 32'd1000);
        resetDut();
        idle(3);
        clr_color = 12'h0E0;
        applyStimulus(10'h3FF, 10'h3FF, 1'b0, 8'd0, 7'd0, 12'h000, 1'b1);
        idle(30);
        resetDut();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
